// File: rtl/strobe_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : strobe_pulse_gen
// Description : Queues single-cycle trigger requests and emits them as
//               fixed-width strobe pulses, each HIGH_CYCLES wide and followed
//               by at least GAP_CYCLES low cycles. A pulse only launches while
//               hold_i is low and is cut short if hold_i rises mid-pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1       rising-edge clock
//   rst_n       in   1       synchronous active-low reset
//   req_i       in   1       trigger request, one request per sampled-high cycle
//   hold_i      in   1       downstream inhibit; no pulse may run while high
//   strobe_o    out  1       shaped strobe (registered)
//   busy_o      out  1       FSM is not idle
//   done_o      out  1       one-cycle pulse: a pulse ran its full width
//   abort_o     out  1       one-cycle pulse: a pulse was truncated by hold_i
//   overflow_o  out  1       one-cycle pulse: request dropped, queue full
//   pend_o      out  PEND_W  requests queued but not yet launched
// ============================================================================
module strobe_pulse_gen #(
    parameter int HIGH_CYCLES = 2,
    parameter int GAP_CYCLES  = 1,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              hold_i,
    output logic              strobe_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              abort_o,
    output logic              overflow_o,
    output logic [PEND_W-1:0] pend_o
);

    // One shared down-counter times both the high phase and the gap phase,
    // so it is sized for whichever of the two is longer.
    localparam int c_CNT_MAX = ((HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES) - 1;
    localparam int c_CNT_W   = (c_CNT_MAX > 0) ? $clog2(c_CNT_MAX + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_HIGH_LOAD = c_CNT_W'(HIGH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [PEND_W-1:0]  c_PEND_MAX  = '1;
    localparam logic [PEND_W-1:0]  c_PEND_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [PEND_W-1:0]   r_pend;
    logic                r_strobe;
    logic                r_busy;
    logic                r_done;
    logic                r_abort;
    logic                r_ovf;

    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_launch;
    logic                w_done_nxt;
    logic                w_abort_nxt;
    logic                w_ovf_nxt;
    logic                w_inc;
    logic [PEND_W-1:0]   w_pend_nxt;

    // ------------------------------------------------------------------
    // Next-state / pulse-shaping logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Uses the registered queue depth, so a request can never
                // launch on the same edge it is captured.
                if ((r_pend != c_PEND_ZERO) && !hold_i) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = c_HIGH_LOAD;
                end
            end

            S_HIGH: begin
                // hold_i wins over normal completion, even on the last
                // high cycle; the aborted request is not retried.
                if (hold_i) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                end else if (r_cnt == c_CNT_ZERO) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end

            S_GAP: begin
                if (r_cnt == c_CNT_ZERO) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending-request queue depth
    // ------------------------------------------------------------------
    // A full queue still accepts a request on a launch edge, because the
    // launch frees a slot on that same edge.
    always_comb begin
        w_ovf_nxt  = req_i && (r_pend == c_PEND_MAX) && !w_launch;
        w_inc      = req_i && !w_ovf_nxt;
        w_pend_nxt = r_pend + PEND_W'(w_inc) - PEND_W'(w_launch);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= c_CNT_ZERO;
            r_pend   <= c_PEND_ZERO;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend   <= w_pend_nxt;
            // Outputs are registered copies of the decoded next state so
            // they line up with r_state after each edge.
            r_strobe <= (w_state_nxt == S_HIGH);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_done_nxt;
            r_abort  <= w_abort_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    assign strobe_o   = r_strobe;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign abort_o    = r_abort;
    assign overflow_o = r_ovf;
    assign pend_o     = r_pend;

endmodule
`default_nettype wire
